// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizes for the regfile_mp register file
package regfile_pkg;

    localparam int REGFILE_N = 8;
    localparam int REGFILE_A = 5;

    typedef enum logic {IDLE, CLEAR} clr_state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/writeback bus of the register file
//   master drives write port, read addresses and clear request
//   slave returns read data/valid, busy and write-drop status
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int N = REGFILE_N,
    parameter int A = REGFILE_A
);

    logic         we;
    logic [A-1:0] waddr;
    logic [N-1:0] wdata;
    logic [A-1:0] raddr1;
    logic [A-1:0] raddr2;
    logic [N-1:0] rdata1;
    logic [N-1:0] rdata2;
    logic         rvalid1;
    logic         rvalid2;
    logic         clr_req;
    logic         busy;
    logic         wr_drop;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, clr_req,
        input  rdata1, rdata2, rvalid1, rvalid2, busy, wr_drop
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, clr_req,
        output rdata1, rdata2, rvalid1, rvalid2, busy, wr_drop
    );

endinterface

// File: rtl/regfile_mp_clr_fsm.sv
// regfile_clr_fsm: bulk-clear sequencer sweeping every entry once per request
//   clk, reset : clock, asynchronous active-high reset
//   clr_req    : start a sweep (ignored while one is running)
//   busy       : registered, high for exactly 2**A cycles per sweep
//   clr_en     : clear the entry at clr_ptr on the next edge
//   clr_ptr    : entry being cleared this cycle
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int A = REGFILE_A
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_req,
    output logic         busy,
    output logic         clr_en,
    output logic [A-1:0] clr_ptr
);

    clr_state_t state_q;

    assign clr_en = (state_q == CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            clr_ptr <= '0;
            busy    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_q <= CLEAR;
                        clr_ptr <= '0;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    // last entry is cleared on this edge, so leave the sweep together with it
                    if (clr_ptr == '1) begin
                        state_q <= IDLE;
                        clr_ptr <= '0;
                        busy    <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised 2-read/1-write register file with valid bits,
// optional hardwired zero entry, write-to-read bypass and bulk-clear sweep
//   clk, reset : clock, asynchronous active-high reset
//   bus        : regfile_mp_if slave (write port, two read ports, clear handshake)
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int N        = REGFILE_N,
    parameter int A        = REGFILE_A,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    regfile_mp_if.slave bus
);

    localparam int DEPTH = 2 ** A;

    logic [N-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic             clr_en;
    logic [A-1:0]     clr_ptr;
    logic             wr_ok;
    logic             hit1;
    logic             hit2;
    logic             zero1;
    logic             zero2;

    regfile_clr_fsm #(.A(A)) u_clr_fsm (
        .clk     (clk),
        .reset   (reset),
        .clr_req (bus.clr_req),
        .busy    (bus.busy),
        .clr_en  (clr_en),
        .clr_ptr (clr_ptr)
    );

    // writes to the hardwired zero entry vanish without raising wr_drop
    assign wr_ok       = bus.we && !bus.busy && !(ZERO_REG && bus.waddr == '0);
    assign bus.wr_drop = bus.we && bus.busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            valid_q <= '0;
        end else if (clr_en) begin
            mem_q[clr_ptr]   <= '0;
            valid_q[clr_ptr] <= 1'b0;
        end else if (wr_ok) begin
            mem_q[bus.waddr]   <= bus.wdata;
            valid_q[bus.waddr] <= 1'b1;
        end
    end

    assign zero1 = ZERO_REG && bus.raddr1 == '0;
    assign zero2 = ZERO_REG && bus.raddr2 == '0;
    assign hit1  = BYPASS && wr_ok && bus.waddr == bus.raddr1;
    assign hit2  = BYPASS && wr_ok && bus.waddr == bus.raddr2;

    assign bus.rdata1  = zero1 ? '0 : hit1 ? bus.wdata : mem_q[bus.raddr1];
    assign bus.rdata2  = zero2 ? '0 : hit2 ? bus.wdata : mem_q[bus.raddr2];
    assign bus.rvalid1 = zero1 || hit1 || valid_q[bus.raddr1];
    assign bus.rvalid2 = zero2 || hit2 || valid_q[bus.raddr2];

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (bypass and non-bypass instances)
module tb_regfile_mp;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total = 0;
    int   n;

    always #5 clk = ~clk;

    regfile_mp_if #(.N(8), .A(5)) ia ();
    regfile_mp_if #(.N(8), .A(5)) ib ();

    assign ib.we      = ia.we;
    assign ib.waddr   = ia.waddr;
    assign ib.wdata   = ia.wdata;
    assign ib.raddr1  = ia.raddr1;
    assign ib.raddr2  = ia.raddr2;
    assign ib.clr_req = ia.clr_req;

    regfile_mp #(.N(8), .A(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ia));
    regfile_mp #(.N(8), .A(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ib));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ia.we = 0; ia.waddr = 0; ia.wdata = 0;
        ia.raddr1 = 0; ia.raddr2 = 0; ia.clr_req = 0;
        tick();
        tick();
        reset = 0;
        ia.raddr1 = 1; ia.raddr2 = 0;
        #1;
        chk("rst_rdata1", ia.rdata1, 0);
        chk("rst_rvalid1", ia.rvalid1, 0);
        chk("rst_rdata2", ia.rdata2, 0);
        chk("rst_rvalid2", ia.rvalid2, 1);
        chk("rst_busy", ia.busy, 0);
        chk("rst_wr_drop", ia.wr_drop, 0);

        tick();
        ia.we = 1; ia.waddr = 3; ia.wdata = 8'h07; ia.raddr1 = 3;
        #1;
        chk("byp_rdata1", ia.rdata1, 8'h07);
        chk("byp_rvalid1", ia.rvalid1, 1);
        chk("nobyp_rdata1", ib.rdata1, 0);
        chk("nobyp_rvalid1", ib.rvalid1, 0);
        tick();
        ia.we = 0;
        #1;
        chk("byp_after_rdata1", ia.rdata1, 8'h07);
        chk("nobyp_after_rdata1", ib.rdata1, 8'h07);
        chk("nobyp_after_rvalid1", ib.rvalid1, 1);

        ia.we = 1; ia.waddr = 0; ia.wdata = 8'h06; ia.raddr2 = 0;
        #1;
        chk("zero_wr_drop", ia.wr_drop, 0);
        chk("zero_byp_rdata2", ia.rdata2, 0);
        tick();
        ia.we = 0;
        #1;
        chk("zero_rdata2", ia.rdata2, 0);
        chk("zero_rvalid2", ia.rvalid2, 1);

        ia.we = 1; ia.waddr = 31; ia.wdata = 8'hAA;
        tick();
        ia.we = 0; ia.clr_req = 1; ia.raddr1 = 31;
        tick();
        ia.clr_req = 0;
        n = 0;
        while (ia.busy && n < 64) begin
            if (n == 5) ia.clr_req = 1;
            if (n == 10) begin
                ia.we = 1; ia.waddr = 5; ia.wdata = 8'h55; ia.raddr2 = 5;
                #1;
                chk("sweep_wr_drop", ia.wr_drop, 1);
                chk("sweep_no_byp_rdata2", ia.rdata2, 0);
                chk("sweep_no_byp_rvalid2", ia.rvalid2, 0);
            end
            if (n == 30) begin
                #1;
                chk("sweep_e31_pre", ia.rdata1, 8'hAA);
            end
            if (n == 31) begin
                #1;
                chk("sweep_e31_last", ia.rdata1, 8'hAA);
                chk("sweep_e31_last_v", ia.rvalid1, 1);
            end
            tick();
            ia.we = 0; ia.clr_req = 0;
            n++;
        end
        chk("sweep_len", n, 32);
        chk("post_e31_rdata", ia.rdata1, 0);
        chk("post_e31_rvalid", ia.rvalid1, 0);
        chk("post_e5_rdata", ia.rdata2, 0);
        chk("post_e5_rvalid", ia.rvalid2, 0);
        ia.raddr1 = 3;
        #1;
        chk("post_e3_rdata", ia.rdata1, 0);
        chk("post_e3_rvalid", ia.rvalid1, 0);

        ia.we = 1; ia.waddr = 7; ia.wdata = 8'h77; ia.raddr1 = 7;
        #1;
        chk("first_wr_drop", ia.wr_drop, 0);
        chk("first_wr_byp", ia.rdata1, 8'h77);
        tick();
        ia.waddr = 9; ia.wdata = 8'h99;
        tick();
        ia.we = 0; ia.raddr2 = 9;
        #1;
        chk("e7_written", ia.rdata1, 8'h77);
        chk("e9_written", ia.rdata2, 8'h99);

        ia.clr_req = 1;
        tick();
        ia.clr_req = 0;
        repeat (10) tick();
        chk("mid_busy", ia.busy, 1);
        reset = 1;
        #1;
        chk("abort_busy_a", ia.busy, 0);
        chk("abort_busy_b", ib.busy, 0);
        chk("abort_e7", ia.rdata1, 0);
        chk("abort_e9", ia.rdata2, 0);
        tick();
        reset = 0;
        for (int i = 1; i < 32; i++) begin
            ia.raddr1 = 5'(i);
            #1;
            chk("abort_scan_rdata", ia.rdata1, 0);
            chk("abort_scan_rvalid", ia.rvalid1, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
